// File: rtl/cycle_sequencer_if.sv
// rtl/cycle_sequencer_if.sv - decoder requests and T-state strobes of the 6502 cycle sequencer
interface cycle_sequencer_if;
  logic       n_ready;
  logic [2:0] len;
  logic       end_early;
  logic       int_req;
  logic       T0;
  logic       T1;
  logic       SYNC;
  logic       n_T2;
  logic       n_T3;
  logic       n_T4;
  logic       n_T5;
  logic       T6;
  logic       T7;
  logic [2:0] cyc;
  logic       int_ack;
  logic       rst_seq;

  modport master (
    output n_ready, len, end_early, int_req,
    input  T0, T1, SYNC, n_T2, n_T3, n_T4, n_T5, T6, T7, cyc, int_ack, rst_seq
  );

  modport slave (
    input  n_ready, len, end_early, int_req,
    output T0, T1, SYNC, n_T2, n_T3, n_T4, n_T5, T6, T7, cyc, int_ack, rst_seq
  );
endinterface

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - 6502 instruction cycle scheduler (T0..T7, SYNC)
// CYCSEQ_RESET_SEQ_EN defined: a RESET_LEN-cycle reset sequence runs before the first fetch.
module cycle_sequencer #(
  parameter int unsigned RESET_LEN = 7
) (
  input  logic PHI0,
  input  logic RES,
  cycle_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'd0,
    KIND_INT    = 2'd1,
    KIND_RESET  = 2'd2
  } kind_e;

  localparam logic [2:0] RESET_LEN_C = 3'(RESET_LEN);
`ifdef CYCSEQ_RESET_SEQ_EN
  localparam kind_e KIND_AFTER_RESET = KIND_RESET;
`else
  localparam kind_e KIND_AFTER_RESET = KIND_NORMAL;
`endif

  logic [2:0] cyc_q, cyc_d;
  logic [2:0] cur_len_q, cur_len_d;
  kind_e      kind_q, kind_d;
  logic [2:0] len_clamped;
  logic       last;

  assign len_clamped = (bus.len < 3'd2) ? 3'd2 : bus.len;

  // cycle 1 never matches cur_len (always >= 2), so a stale cur_len is harmless there
  assign last = (cyc_q == cur_len_q) ||
                (bus.end_early && (cyc_q != 3'd1) && (kind_q == KIND_NORMAL));

  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      cyc_q     <= 3'd1;
      cur_len_q <= RESET_LEN_C;
      kind_q    <= KIND_AFTER_RESET;
    end else begin
      cyc_q     <= cyc_d;
      cur_len_q <= cur_len_d;
      kind_q    <= kind_d;
    end
  end

  always_comb begin
    cyc_d     = cyc_q;
    cur_len_d = cur_len_q;
    kind_d    = kind_q;
    if (!bus.n_ready) begin
      if (last) begin
        cyc_d  = 3'd1;
        kind_d = bus.int_req ? KIND_INT : KIND_NORMAL;
      end else if (cyc_q == 3'd1) begin
        cyc_d = 3'd2;
        case (kind_q)
          KIND_INT:   cur_len_d = 3'd7;
          KIND_RESET: cur_len_d = RESET_LEN_C;
          default:    cur_len_d = len_clamped;
        endcase
      end else begin
        cyc_d = cyc_q + 3'd1;
      end
    end
  end

  assign bus.T0      = last;
  assign bus.T1      = (cyc_q == 3'd1);
  assign bus.n_T2    = (cyc_q != 3'd2);
  assign bus.n_T3    = (cyc_q != 3'd3);
  assign bus.n_T4    = (cyc_q != 3'd4);
  assign bus.n_T5    = (cyc_q != 3'd5);
  assign bus.T6      = (cyc_q == 3'd6);
  assign bus.T7      = (cyc_q == 3'd7);
  assign bus.cyc     = cyc_q;
  assign bus.SYNC    = (cyc_q == 3'd1) && (kind_q == KIND_NORMAL);
  assign bus.int_ack = (cyc_q == 3'd1) && (kind_q == KIND_INT);
`ifdef CYCSEQ_RESET_SEQ_EN
  assign bus.rst_seq = (kind_q == KIND_RESET);
`else
  assign bus.rst_seq = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - directed self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

  logic PHI0;
  logic RES;
  int   n_cmp;
  int   n_bad;
  logic [13:0] got;

  cycle_sequencer_if bus ();

  cycle_sequencer #(.RESET_LEN(7)) dut (
    .PHI0 (PHI0),
    .RES  (RES),
    .bus  (bus)
  );

  initial PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  function automatic logic [13:0] obs();
    return {bus.T0, bus.T1, bus.SYNC, bus.n_T2, bus.n_T3, bus.n_T4, bus.n_T5,
            bus.T6, bus.T7, bus.int_ack, bus.rst_seq, bus.cyc};
  endfunction

  // expected output vector in obs() order, built from cycle number and flags
  function automatic logic [13:0] mk(input logic t0, input logic [2:0] c,
                                     input logic sync, input logic ack, input logic rs);
    return {t0, c == 3'd1, sync, c != 3'd2, c != 3'd3, c != 3'd4, c != 3'd5,
            c == 3'd6, c == 3'd7, ack, rs, c};
  endfunction

`ifdef CYCSEQ_RESET_SEQ_EN
  localparam logic [13:0] RESET_VEC = 14'b0_1_0_1111_00_0_1_001;
`else
  localparam logic [13:0] RESET_VEC = 14'b0_1_1_1111_00_0_0_001;
`endif

  task automatic post_reset_sequence(input string name);
`ifdef CYCSEQ_RESET_SEQ_EN
    logic [13:0] ev [8];
    for (int i = 0; i < 7; i++) ev[i] = mk(i == 6, 3'(i + 1), 1'b0, 1'b0, 1'b1);
    ev[7] = mk(0, 3'd1, 1, 0, 0);
    bus.len = 3'd3;
    for (int i = 0; i < 8; i++) begin
`else
    logic [13:0] ev [3];
    ev = '{mk(0, 3'd1, 1, 0, 0), mk(1, 3'd2, 0, 0, 0), mk(0, 3'd1, 1, 0, 0)};
    bus.len = 3'd0;
    for (int i = 0; i < 3; i++) begin
`endif
      if (i > 0) @(negedge PHI0);
      #1;
      got = obs();
      n_cmp++;
      if (got !== ev[i]) begin
        n_bad++;
        $display("FAIL %s step %0d: got %b expected %b", name, i, got, ev[i]);
      end
    end
  endtask

  task automatic test_reset();
    RES = 1'b1;
    bus.n_ready = 1'b0; bus.len = 3'd2; bus.end_early = 1'b0; bus.int_req = 1'b0;
    @(negedge PHI0);
    @(negedge PHI0);
    #1;
    got = obs();
    n_cmp++;
    if (got !== RESET_VEC) begin
      n_bad++;
      $display("FAIL reset_values: got %b expected %b", got, RESET_VEC);
    end
    @(negedge PHI0);
    RES = 1'b0;
    post_reset_sequence("reset_release");
  endtask

  task automatic test_normal_len4();
    logic [13:0] ev [5];
    ev = '{mk(0, 3'd1, 1, 0, 0), mk(0, 3'd2, 0, 0, 0), mk(0, 3'd3, 0, 0, 0),
           mk(1, 3'd4, 0, 0, 0), mk(0, 3'd1, 1, 0, 0)};
    bus.len = 3'd4;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge PHI0);
      #1;
      got = obs();
      n_cmp++;
      if (got !== ev[i]) begin
        n_bad++;
        $display("FAIL normal_len4 step %0d: got %b expected %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_end_early();
    logic [13:0] ev [4];
    logic [3:0]  ee;
    ev = '{mk(0, 3'd1, 1, 0, 0), mk(0, 3'd2, 0, 0, 0), mk(1, 3'd3, 0, 0, 0),
           mk(0, 3'd1, 1, 0, 0)};
    ee = 4'b0101;
    bus.len = 3'd5;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge PHI0);
      bus.end_early = ee[i];
      #1;
      got = obs();
      n_cmp++;
      if (got !== ev[i]) begin
        n_bad++;
        $display("FAIL end_early step %0d: got %b expected %b", i, got, ev[i]);
      end
    end
    bus.end_early = 1'b0;
  endtask

  task automatic test_stall();
    logic [13:0] ev [6];
    logic [5:0]  rdy, ee, irq;
    ev = '{mk(0, 3'd1, 1, 0, 0), mk(0, 3'd2, 0, 0, 0), mk(1, 3'd2, 0, 0, 0),
           mk(0, 3'd2, 0, 0, 0), mk(1, 3'd3, 0, 0, 0), mk(0, 3'd1, 1, 0, 0)};
    rdy = 6'b000110;
    ee  = 6'b000100;
    irq = 6'b000010;
    bus.len = 3'd3;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge PHI0);
      bus.n_ready = rdy[i]; bus.end_early = ee[i]; bus.int_req = irq[i];
      #1;
      got = obs();
      n_cmp++;
      if (got !== ev[i]) begin
        n_bad++;
        $display("FAIL stall step %0d: got %b expected %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_interrupt();
    logic [13:0] ev [11];
    logic [10:0] rdy, ee, irq;
    ev = '{mk(0, 3'd1, 1, 0, 0), mk(1, 3'd2, 0, 0, 0), mk(1, 3'd2, 0, 0, 0),
           mk(0, 3'd1, 0, 1, 0), mk(0, 3'd2, 0, 0, 0), mk(0, 3'd3, 0, 0, 0),
           mk(0, 3'd4, 0, 0, 0), mk(0, 3'd5, 0, 0, 0), mk(0, 3'd6, 0, 0, 0),
           mk(1, 3'd7, 0, 0, 0), mk(0, 3'd1, 1, 0, 0)};
    rdy = 11'b00000000010;
    ee  = 11'b00001000000;
    irq = 11'b00000000100;
    bus.len = 3'd2;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge PHI0);
      bus.n_ready = rdy[i]; bus.end_early = ee[i]; bus.int_req = irq[i];
      #1;
      got = obs();
      n_cmp++;
      if (got !== ev[i]) begin
        n_bad++;
        $display("FAIL interrupt step %0d: got %b expected %b", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_reset_midway();
    bus.len = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge PHI0);
      #1;
      got = obs();
      n_cmp++;
      if (got !== mk(0, 3'(i + 1), i == 0, 0, 0)) begin
        n_bad++;
        $display("FAIL midway_run step %0d: got %b expected %b", i, got,
                 mk(0, 3'(i + 1), i == 0, 0, 0));
      end
    end
    #2 RES = 1'b1;
    #1;
    got = obs();
    n_cmp++;
    if (got !== RESET_VEC) begin
      n_bad++;
      $display("FAIL midway_async_reset: got %b expected %b", got, RESET_VEC);
    end
    @(negedge PHI0);
    RES = 1'b0;
    post_reset_sequence("midway_restart");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_normal_len4();
    test_end_early();
    test_stall();
    test_interrupt();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
